// File: rtl/prog_mem_loader_if.sv
// prog_mem_loader_if: byte load stream and CPU fetch port of the program memory loader
interface prog_mem_loader_if #(
   parameter int WORD_W = 32,
   parameter int ADDR_W = 8
);
   logic              load_valid;
   logic [7:0]        load_byte;
   logic              load_last;
   logic              load_ready;
   logic              fetch_req;
   logic [ADDR_W-1:0] fetch_addr;
   logic              fetch_valid;
   logic [WORD_W-1:0] fetch_data;
   logic              fetch_err;
   modport master (
      output load_valid, load_byte, load_last, fetch_req, fetch_addr,
      input  load_ready, fetch_valid, fetch_data, fetch_err
   );
   modport slave (
      input  load_valid, load_byte, load_last, fetch_req, fetch_addr,
      output load_ready, fetch_valid, fetch_data, fetch_err
   );
endinterface

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: big-endian byte stream to word memory loader with CPU fetch port; PROG_MEM_LOADER_CHECKSUM_EN adds an XOR checksum output
module prog_mem_loader #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              restart,
   prog_mem_loader_if.slave  bus,
   output logic              cpu_hold,
   output logic [ADDR_W-1:0] words_loaded,
   output logic              load_err
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]        checksum
`endif
);
   localparam int NB = WORD_W / 8;
   localparam int BW = NB > 1 ? $clog2(NB) : 1;
   localparam int PW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(DEPTH);
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
   state_t            state, state_n;
   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] acc, acc_n;
   logic [BW-1:0]     bcnt;
   logic [PW-1:0]     wr_ptr;
   logic              acc_ok, full, wr_en, clr, hit, serve;
   assign acc_ok = bus.load_valid && bus.load_ready;
   assign full   = wr_ptr == PW'(DEPTH);
   assign wr_en  = acc_ok && !full && (bcnt == BW'(NB - 1) || bus.load_last);
   assign acc_n  = acc | (WORD_W'(bus.load_byte) << (WORD_W - 8 - 8 * int'(bcnt)));
   assign clr    = !reset || (state == RUN && restart);
   assign hit    = 32'(bus.fetch_addr) < 32'(wr_ptr);
   assign serve  = state == RUN && bus.fetch_req;
   assign words_loaded = ADDR_W'(wr_ptr);
   // state register
   always_ff @(posedge clk)
      state <= !reset ? IDLE : state_n;
   // next state: first byte leaves IDLE, a last byte ends loading, restart leaves RUN
   always_comb
      state_n = state == RUN ? (restart ? IDLE : RUN) : acc_ok ? (bus.load_last ? RUN : LOAD) : state;
   // loader stays ready and holds the CPU until a program is complete
   always_comb begin
      bus.load_ready = state != RUN;
      cpu_hold       = state != RUN;
   end
   // word assembly; overflow bytes are swallowed and flagged
   always_ff @(posedge clk) begin
      if (clr) begin
         wr_ptr   <= '0;
         bcnt     <= '0;
         acc      <= '0;
         load_err <= 1'b0;
      end else if (acc_ok && full) begin
         load_err <= 1'b1;
      end else if (acc_ok) begin
         acc    <= wr_en ? '0 : acc_n;
         bcnt   <= wr_en ? '0 : bcnt + BW'(1);
         wr_ptr <= wr_en ? wr_ptr + PW'(1) : wr_ptr;
      end
   end
   // memory is never cleared; words_loaded gates what a fetch may see
   always_ff @(posedge clk)
      if (reset && wr_en) mem[IW'(wr_ptr)] <= acc_n;
   // one-cycle fetch response, bounded by words_loaded
   always_ff @(posedge clk) begin
      bus.fetch_valid <= reset && serve;
      bus.fetch_err   <= reset && serve && !hit;
      bus.fetch_data  <= reset && serve && hit ? mem[IW'(bus.fetch_addr)] : '0;
   end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
   // running XOR of every accepted byte, overflow bytes included
   always_ff @(posedge clk)
      checksum <= clr ? 8'h00 : acc_ok ? checksum ^ bus.load_byte : checksum;
`endif
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: random and directed stimulus against a byte-list reference model of prog_mem_loader
module tb_prog_mem_loader;
   logic        clk = 1'b0;
   logic        reset, restart, cpu_hold, load_err;
   logic [7:0]  words_loaded;
   int          checks = 0, errors = 0;
   int          phase = 0;
   logic [7:0]  sess[$];
   logic [7:0]  cs = 8'h00;
   logic        efv = 1'b0, efe = 1'b0;
   logic [31:0] efd = '0;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
   logic [7:0]  checksum;
`endif
   prog_mem_loader_if #(.WORD_W(32), .ADDR_W(8)) bus ();
   prog_mem_loader #(.WORD_W(32), .DEPTH(16), .ADDR_W(8)) dut (
      .clk(clk), .reset(reset), .restart(restart), .bus(bus),
      .cpu_hold(cpu_hold), .words_loaded(words_loaded), .load_err(load_err)
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );
   always #5 clk = ~clk;
   function automatic int wl();
      int n = sess.size();
      int w = phase == 2 ? (n + 3) / 4 : n / 4;
      return w > 16 ? 16 : w;
   endfunction
   function automatic logic [31:0] word_of(int a);
      logic [31:0] w = '0;
      for (int k = 0; k < 4; k++)
         if (4 * a + k < sess.size()) w[31 - 8 * k -: 8] = sess[4 * a + k];
      return w;
   endfunction
   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask
   task automatic model_step();
      if (!reset) begin
         phase = 0;
         sess.delete();
         cs = 8'h00;
         efv = 1'b0;
         efe = 1'b0;
         efd = '0;
      end else begin
         efv = phase == 2 && bus.fetch_req;
         efe = efv && int'(bus.fetch_addr) >= wl();
         efd = efv && !efe ? word_of(int'(bus.fetch_addr)) : '0;
         if (phase == 2) begin
            if (restart) begin
               phase = 0;
               sess.delete();
               cs = 8'h00;
            end
         end else if (bus.load_valid) begin
            sess.push_back(bus.load_byte);
            cs ^= bus.load_byte;
            phase = bus.load_last ? 2 : 1;
         end
      end
   endtask
   task automatic check();
      chk("load_ready", 32'(bus.load_ready), 32'(phase != 2));
      chk("cpu_hold", 32'(cpu_hold), 32'(phase != 2));
      chk("words_loaded", 32'(words_loaded), 32'(wl()));
      chk("load_err", 32'(load_err), 32'(sess.size() > 64));
      chk("fetch_valid", 32'(bus.fetch_valid), 32'(efv));
      if (efv) begin
         chk("fetch_err", 32'(bus.fetch_err), 32'(efe));
         chk("fetch_data", bus.fetch_data, efd);
      end
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
      chk("checksum", 32'(checksum), 32'(cs));
`endif
   endtask
   task automatic step();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check();
   endtask
   task automatic quiet();
      bus.load_valid = 1'b0;
      bus.load_last  = 1'b0;
      bus.fetch_req  = 1'b0;
      restart        = 1'b0;
   endtask
   task automatic send(logic [7:0] b, logic last);
      bus.load_valid = 1'b1;
      bus.load_byte  = b;
      bus.load_last  = last;
      step();
      quiet();
   endtask
   task automatic fetch(logic [7:0] a);
      bus.fetch_req  = 1'b1;
      bus.fetch_addr = a;
      step();
      quiet();
   endtask
   task automatic do_restart();
      restart = 1'b1;
      step();
      quiet();
   endtask
   task automatic do_reset();
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask
   initial begin
      logic [7:0]  fa [4] = '{8'd0, 8'd1, 8'd2, 8'd0};
      logic [31:0] fd [4] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h00010203};
      bus.load_byte  = 8'h00;
      bus.fetch_addr = '0;
      quiet();
      do_reset();
      chk("reset_load_ready", 32'(bus.load_ready), 32'd1);
      chk("reset_cpu_hold", 32'(cpu_hold), 32'd1);
      for (int i = 1; i <= 8; i++) send(8'(i), i == 8);
      chk("seq8_words", 32'(words_loaded), 32'd2);
      chk("seq8_run", 32'(cpu_hold), 32'd0);
      fetch(8'd0);
      chk("seq8_w0", bus.fetch_data, 32'h01020304);
      fetch(8'd1);
      chk("seq8_w1", bus.fetch_data, 32'h05060708);
      chk("seq8_err", 32'(bus.fetch_err), 32'd0);
      do_restart();
      for (int i = 0; i < 6; i++) send(8'hAA + 8'(17 * i), i == 5);
      chk("six_words", 32'(words_loaded), 32'd2);
      fetch(8'd1);
      chk("six_w1", bus.fetch_data, 32'hEEFF0000);
      do_restart();
      for (int i = 0; i < 68; i++) begin
         send(8'(i), i == 67);
         chk("ovf_ready", 32'(bus.load_ready), 32'(i != 67));
      end
      chk("ovf_err", 32'(load_err), 32'd1);
      chk("ovf_words", 32'(words_loaded), 32'd16);
      fetch(8'd16);
      chk("ovf_f16_valid", 32'(bus.fetch_valid), 32'd1);
      chk("ovf_f16_data", bus.fetch_data, 32'd0);
      chk("ovf_f16_err", 32'(bus.fetch_err), 32'd1);
      bus.fetch_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.fetch_addr = fa[i];
         step();
         chk("b2b_valid", 32'(bus.fetch_valid), 32'd1);
         chk("b2b_data", bus.fetch_data, fd[i]);
      end
      quiet();
      restart = 1'b1;
      bus.fetch_req = 1'b1;
      bus.fetch_addr = 8'd1;
      step();
      quiet();
      chk("rst_fetch_valid", 32'(bus.fetch_valid), 32'd1);
      chk("rst_fetch_data", bus.fetch_data, 32'h04050607);
      chk("restart_hold", 32'(cpu_hold), 32'd1);
      chk("restart_words", 32'(words_loaded), 32'd0);
      fetch(8'd0);
      chk("idle_fetch", 32'(bus.fetch_valid), 32'd0);
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
      send(8'h12, 1'b0);
      send(8'h34, 1'b0);
      send(8'h56, 1'b0);
      chk("cs_value", 32'(checksum), 32'h70);
      do_reset();
      send(8'h9A, 1'b0);
      send(8'hBC, 1'b0);
      do_reset();
      chk("cs_reset", 32'(checksum), 32'd0);
      chk("cs_reset_words", 32'(words_loaded), 32'd0);
      chk("cs_reset_idle", 32'(cpu_hold), 32'd1);
`endif
      for (int c = 0; c < 4000; c++) begin
         reset          = $urandom_range(0, 99) != 0;
         restart        = $urandom_range(0, 19) == 0;
         bus.load_valid = $urandom_range(0, 9) < 7;
         bus.load_byte  = 8'($urandom);
         bus.load_last  = $urandom_range(0, 19) == 0;
         bus.fetch_req  = $urandom_range(0, 9) < 6;
         bus.fetch_addr = 8'($urandom_range(0, 19));
         step();
      end
      reset = 1'b1;
      quiet();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/prog_mem_loader.md
PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, instruction word width in bits; legal values are multiples of 8 with WORD_W >= 8.
REQ-002 SHALL have parameter DEPTH, default 16, number of words stored; legal values are 2..256.
REQ-003 SHALL have parameter ADDR_W, default 8, width of fetch_addr and words_loaded.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous active-low reset: sampled on the clk rising edge, with 0 meaning reset.
REQ-006 SHALL have ports load_valid (input, 1), load_byte (input, 8), load_last (input, 1) and load_ready (output, 1), forming the byte load stream; a byte transfers on a clk edge where load_valid and load_ready are both 1.
REQ-007 SHALL have port restart, input, 1 bit, which returns the block from RUN to IDLE.
REQ-008 SHALL have ports fetch_req (input, 1) and fetch_addr (input, ADDR_W), the CPU fetch request.
REQ-009 SHALL have ports fetch_valid (output, 1), fetch_data (output, WORD_W) and fetch_err (output, 1), the fetch response.
REQ-010 SHALL have port cpu_hold, output, 1 bit, which holds the CPU in reset while a program is loading.
REQ-011 SHALL have ports words_loaded (output, ADDR_W) and load_err (output, 1), the load status.

Function
REQ-012 SHALL implement three states: IDLE, LOAD and RUN.
REQ-013 SHALL, in IDLE: drive load_ready=1 and cpu_hold=1, and move to LOAD on the first accepted byte.
REQ-014 SHALL, in LOAD: drive load_ready=1 and cpu_hold=1.
REQ-015 SHALL, in RUN: drive load_ready=0 and cpu_hold=0.
REQ-016 SHALL assemble bytes big-endian: the first byte of a word fills bits [WORD_W-1:WORD_W-8]; every WORD_W/8 accepted bytes write one word at wr_ptr, after which wr_ptr and words_loaded increment.
REQ-017 SHALL, on an accepted byte with load_last=1, write the current word with its unfilled low bytes zeroed (if the word holds at least one byte) and enter RUN the following cycle.
REQ-018 SHALL, when a byte would land in word index >= DEPTH: still accept it (load_ready stays 1), discard it, set load_err sticky, and hold words_loaded at DEPTH.
REQ-019 SHALL, in RUN, sample fetch_req and respond one cycle later: fetch_valid=1 and fetch_data=mem[fetch_addr]; fetch_valid=0 in cycles with no request.
REQ-020 SHALL, for a fetch with fetch_addr >= words_loaded (including addr >= DEPTH): return fetch_data=0 with fetch_err=1 for that response cycle; otherwise fetch_err=0.
REQ-021 SHALL accept back-to-back fetch_req every cycle in RUN, with a throughput of one response per cycle.
REQ-022 SHALL ignore fetch_req in IDLE and LOAD, keeping fetch_valid=0.
REQ-023 SHALL, on restart=1 in RUN: enter IDLE next cycle, clear wr_ptr, words_loaded and load_err, and raise cpu_hold; restart is ignored in IDLE and LOAD.
REQ-024 SHALL, when restart and fetch_req coincide, still deliver that fetch's response in the next cycle; no further fetches are served after it.
REQ-025 SHALL retain memory array contents across restart and reset; the words_loaded bound alone gates reads.

Reset
REQ-026 SHALL, on reset=0 at a clk edge, set: state=IDLE, wr_ptr=0, byte counter=0, words_loaded=0, load_err=0, fetch_valid=0, fetch_data=0, fetch_err=0.
REQ-027 SHALL drive load_ready=1 and cpu_hold=1 in the cycle after reset.
REQ-028 SHALL, on reset during LOAD, drop any partial word.
REQ-029 SHALL, on reset during a pending fetch, suppress that fetch's response.

Configuration
REQ-030 SHALL, when macro PROG_MEM_LOADER_CHECKSUM_EN is defined, add output port checksum (8 bits).
REQ-031 SHALL, with PROG_MEM_LOADER_CHECKSUM_EN defined, compute checksum as the running XOR of all accepted bytes, including discarded overflow bytes, cleared by reset and by restart; it updates the cycle after each accepted byte.
REQ-032 SHALL, without PROG_MEM_LOADER_CHECKSUM_EN, omit the checksum port and its logic entirely.

Verification
REQ-033 SHALL cover: after reset, stream 8 bytes 01..08 with load_last on the 8th -> words_loaded=2, RUN; fetch addr 0 -> 0x01020304, addr 1 -> 0x05060708, each 1 cycle after request, fetch_err=0.
REQ-034 SHALL cover: stream 6 bytes AA,BB,CC,DD,EE,FF with load_last on the last -> words_loaded=2, word 1 reads 0xEEFF0000.
REQ-035 SHALL cover: DEPTH=16, stream 68 bytes -> load_err=1, words_loaded=16, load_ready stays 1 throughout; fetch addr 16 -> data 0, fetch_err=1.
REQ-036 SHALL cover: in RUN, fetch_req for 4 consecutive cycles on addrs 0,1,2,0 -> 4 consecutive fetch_valid cycles with the matching data.
REQ-037 SHALL cover: restart in RUN -> next cycle IDLE, cpu_hold=1, words_loaded=0; a fetch of addr 0 before reloading yields fetch_valid=0.
REQ-038 SHALL cover, with PROG_MEM_LOADER_CHECKSUM_EN defined: bytes 0x12,0x34,0x56 -> checksum=0x70; reset=0 mid-LOAD after 2 bytes of a word -> words_loaded=0, checksum=0, state IDLE.
